// File: rtl/rotate_angle_cordic.sv
// rotate_angle_cordic
//   Converts an unsigned rotation phase into the signed sin/cos coefficient
//   pair consumed by the frame rotator. A computation starts on a snooped
//   FRAME_END (or a force_update pulse), runs one CORDIC micro-rotation per
//   clock, applies the quadrant map, rounds/saturates and commits, so fresh
//   coefficients are stable before the next FRAME_START.
//   Output fixed point: 1.0 = 2^(ANGLE_WIDTH-2).
//
// Ports
//   clk          clock
//   resetb       asynchronous active-low reset
//   enable       low forces identity outputs (sin=0, cos=ONE) and aborts work
//   dvi, dtypei  stream valid/dtype, snooped for FRAME_END only
//   phase        rotation angle, 2^PHASE_WIDTH = 360 degrees
//   force_update one-cycle pulse, starts a computation immediately
//   sin_theta    signed sine coefficient
//   cos_theta    signed cosine coefficient
//   busy         high while a computation is in flight
//   done         one-cycle pulse when sin/cos are updated

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd2
`endif

module rotate_angle_cordic #(
    parameter int unsigned ANGLE_WIDTH = 10,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned INT_WIDTH   = 18,
    parameter int unsigned ITER        = 12
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [PHASE_WIDTH-1:0]  phase,
    input  logic                    force_update,
    output logic [ANGLE_WIDTH-1:0]  sin_theta,
    output logic [ANGLE_WIDTH-1:0]  cos_theta,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned ZW   = PHASE_WIDTH + 2;
    localparam int unsigned SH   = INT_WIDTH - ANGLE_WIDTH;
    localparam int unsigned IDXW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic signed [ANGLE_WIDTH-1:0] ONE_O  = ANGLE_WIDTH'(2 ** (ANGLE_WIDTH - 2));
    localparam logic signed [INT_WIDTH-1:0]   SAT_HI = INT_WIDTH'(2 ** (ANGLE_WIDTH - 2));
    localparam logic signed [INT_WIDTH-1:0]   SAT_LO = -SAT_HI;
    localparam logic signed [INT_WIDTH-1:0]   HALF   = INT_WIDTH'(2 ** (SH - 1));
    // Pre-scaled by the CORDIC gain so the result needs no final multiply.
    localparam logic signed [INT_WIDTH-1:0]   X_INIT =
        INT_WIDTH'($rtoi(0.607252935 * (2.0 ** (INT_WIDTH - 2)) + 0.5));

    // atan(2^-k) as a fraction of a full turn.
    function automatic real atan_frac(input int unsigned k);
        case (k)
            0:       return 0.125;
            1:       return 0.0737918088252;
            2:       return 0.0389895421812;
            3:       return 0.0197917336883;
            4:       return 0.0099342214096;
            5:       return 0.0049719343326;
            6:       return 0.0024865840373;
            7:       return 0.0012433540340;
            8:       return 0.0006216950195;
            9:       return 0.0003108496304;
            10:      return 0.0001554248911;
            11:      return 0.0000777124540;
            default: return 1.0 / ((2.0 ** k) * 6.283185307179586);
        endcase
    endfunction

    function automatic logic [ITER*ZW-1:0] build_atan();
        logic [ITER*ZW-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < ITER; k++) begin
            t[k*ZW +: ZW] = ZW'($rtoi(atan_frac(k) * (2.0 ** PHASE_WIDTH) + 0.5));
        end
        return t;
    endfunction

    localparam logic [ITER*ZW-1:0] ATAN_TAB = build_atan();

    // Round half up to the output grid, then clamp to [-ONE, +ONE].
    function automatic logic signed [ANGLE_WIDTH-1:0] scale_sat(input logic signed [INT_WIDTH-1:0] v);
        logic signed [INT_WIDTH-1:0] r;
        r = (v + HALF) >>> SH;
        if (r > SAT_HI) begin
            return ONE_O;
        end else if (r < SAT_LO) begin
            return -ONE_O;
        end
        return r[ANGLE_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_MAP} state_t;

    state_t                         state_q;
    logic signed [INT_WIDTH-1:0]    x_q, y_q;
    logic signed [ZW-1:0]           z_q;
    logic [1:0]                     quad_q;
    logic [IDXW-1:0]                iter_q;
    logic signed [ANGLE_WIDTH-1:0]  sin_q, cos_q;
    logic                           busy_q, done_q;

    logic                           trig;
    logic                           dir;
    logic signed [INT_WIDTH-1:0]    x_sh, y_sh, x_d, y_d;
    logic signed [ZW-1:0]           atan_i, z_d, z0;
    logic signed [INT_WIDTH-1:0]    c_map, s_map;
    logic signed [ANGLE_WIDTH-1:0]  sin_d, cos_d;

    assign trig = (dvi && (dtypei == `DTYPE_FRAME_END)) || force_update;
    assign z0   = {4'b0000, phase[PHASE_WIDTH-3:0]};

    always_comb begin
        dir    = ~z_q[ZW-1];
        x_sh   = x_q >>> iter_q;
        y_sh   = y_q >>> iter_q;
        atan_i = $signed(ATAN_TAB[int'(iter_q)*ZW +: ZW]);
        x_d    = dir ? (x_q - y_sh) : (x_q + y_sh);
        y_d    = dir ? (y_q + x_sh) : (y_q - x_sh);
        z_d    = dir ? (z_q - atan_i) : (z_q + atan_i);

        case (quad_q)
            2'd0:    begin c_map = x_q;  s_map = y_q;  end
            2'd1:    begin c_map = -y_q; s_map = x_q;  end
            2'd2:    begin c_map = -x_q; s_map = -y_q; end
            default: begin c_map = y_q;  s_map = -x_q; end
        endcase
        cos_d = scale_sat(c_map);
        sin_d = scale_sat(s_map);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            quad_q  <= '0;
            iter_q  <= '0;
            sin_q   <= '0;
            cos_q   <= ONE_O;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!enable) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                sin_q   <= '0;
                cos_q   <= ONE_O;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (trig) begin
                            quad_q  <= phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
                            z_q     <= z0;
                            x_q     <= X_INIT;
                            y_q     <= '0;
                            iter_q  <= '0;
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        x_q <= x_d;
                        y_q <= y_d;
                        z_q <= z_d;
                        if (iter_q == IDXW'(ITER - 1)) begin
                            state_q <= S_MAP;
                        end else begin
                            iter_q <= iter_q + 1'b1;
                        end
                    end
                    S_MAP: begin
                        sin_q   <= sin_d;
                        cos_q   <= cos_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sin_theta = sin_q;
    assign cos_theta = cos_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
